boot_copy_seq: RTL

//  Power-up sequencer in front of mem_if. After reset with boot=1 it copies a

---
 rtl/boot_copy_seq_if.sv | 28 ++
 rtl/boot_copy_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/boot_copy_seq_if.sv
// Flash-read and SRAM-write handshake bundle between the boot sequencer and mem_if.
// The sequencer is the master on both ports.
interface boot_copy_seq_if;
    logic        mem_flash_cs;
    logic        mem_flash_rw;
    logic [24:0] mem_flash_addr;
    logic [31:0] mem_flash_data_rd;
    logic        mem_flash_done;
    logic        mem_sram_cs;
    logic        mem_sram_rw;
    logic [21:0] mem_sram_addr;
    logic [31:0] mem_sram_data_wr;
    logic        mem_sram_done;

    modport master (
        output mem_flash_cs, mem_flash_rw, mem_flash_addr,
        input  mem_flash_data_rd, mem_flash_done,
        output mem_sram_cs, mem_sram_rw, mem_sram_addr, mem_sram_data_wr,
        input  mem_sram_done
    );

    modport slave (
        input  mem_flash_cs, mem_flash_rw, mem_flash_addr,
        output mem_flash_data_rd, mem_flash_done,
        input  mem_sram_cs, mem_sram_rw, mem_sram_addr, mem_sram_data_wr,
        output mem_sram_done
    );
endinterface

// File: rtl/boot_copy_seq.sv
// Power-up sequencer: copies a flash image word by word into SRAM, then releases the CPU.
// Owns both memory ports until start rises; err and start are terminal until reset.
module boot_copy_seq #(
    parameter logic [21:0] COPY_WORDS = 22'd4096,
    parameter logic [24:0] BIOS_BASE  = 25'h0000000,
    parameter logic [24:0] OS_BASE    = 25'h0100000,
    parameter logic [21:0] SRAM_BASE  = 22'h000000,
    parameter logic [15:0] TIMEOUT    = 16'd65535
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        boot,
    input  logic        os,
    output logic        start,
    output logic        busy,
    output logic        err,
    output logic [21:0] words_done,
    boot_copy_seq_if.master mem
);

    typedef enum logic [2:0] {IDLE, FREAD, SWRITE, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [24:0] src_q, src_d;
    logic [21:0] dst_q, dst_d;
    logic [31:0] data_q, data_d;
    logic [21:0] words_q, words_d;
    logic [15:0] tmo_q, tmo_d;
    logic        start_q, start_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            words_q <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        words_d = words_q;
        tmo_d   = tmo_q;
        start_d = start_q;
        unique case (state_q)
            IDLE: begin
                if (!boot || COPY_WORDS == 22'd0) begin
                    state_d = DONE;
                end else begin
                    src_d   = os ? OS_BASE : BIOS_BASE;
                    dst_d   = SRAM_BASE;
                    tmo_d   = '0;
                    state_d = FREAD;
                end
            end
            FREAD: begin
                // A done on the same edge the counter expires still completes the read.
                if (mem.mem_flash_done) begin
                    data_d  = mem.mem_flash_data_rd;
                    tmo_d   = '0;
                    state_d = SWRITE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (tmo_d == TIMEOUT) state_d = ERR;
                end
            end
            SWRITE: begin
                if (mem.mem_sram_done) begin
                    words_d = words_q + 22'd1;
                    src_d   = src_q + 25'd1;
                    dst_d   = dst_q + 22'd1;
                    tmo_d   = '0;
                    state_d = (words_d == COPY_WORDS) ? DONE : FREAD;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (tmo_d == TIMEOUT) state_d = ERR;
                end
            end
            DONE:    start_d = 1'b1;
            ERR:     ;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign mem.mem_flash_cs     = (state_q == FREAD);
    assign mem.mem_flash_rw     = 1'b0;
    assign mem.mem_flash_addr   = src_q;
    assign mem.mem_sram_cs      = (state_q == SWRITE);
    assign mem.mem_sram_rw      = (state_q == SWRITE);
    assign mem.mem_sram_addr    = dst_q;
    assign mem.mem_sram_data_wr = data_q;

    assign busy       = (state_q == FREAD) || (state_q == SWRITE);
    assign err        = (state_q == ERR);
    assign start      = start_q;
    assign words_done = words_q;

endmodule
